cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-mapped responder for an 8-bit CPU bus.
//   $0000-$1FFF  RAM   2 KiB, mirrored on addr[10:0]
//   $2000-$3FFF  IO    8 registers, mirrored on addr[2:0]
//   $4000-$5FFF  unmapped
//   $6000-$7FFF  SRAM  8 KiB on addr[12:0]
//   $8000-$FFFF  ROM   32 KiB on addr[14:0], ROM_WAIT wait cycles per read
// ROM contents are fixed logic: byte 0 holds 8'h4C and every other byte
// holds idx[7:0] ^ {1'b0, idx[14:8]}.
// Build option: define CPU_MEM_OPEN_BUS_EN to make unmapped reads leave
// cpu_data_in unchanged (open bus). Without it, unmapped reads return 8'h00.

module cpu_mem_responder #(
    parameter int ROM_WAIT = 2
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        ren,
    input  logic        wen,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    output logic        io_wr,
    output logic [2:0]  io_sel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RG_RAM  = 3'd0,
        RG_IO   = 3'd1,
        RG_NONE = 3'd2,
        RG_SRAM = 3'd3,
        RG_ROM  = 3'd4
    } region_t;

    // A zero wait count makes ROM behave like the single-cycle regions.
    localparam bit         ROM_HAS_WAIT = (ROM_WAIT > 0);
    localparam logic [2:0] WAIT_LOAD    = 3'(ROM_WAIT - 1);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [14:0] rom_idx;

    logic [7:0]  ram     [0:2047];
    logic [7:0]  sram    [0:8191];
    logic [7:0]  io_regs [0:7];

    region_t     region;
    logic        accept;
    logic        wr_fire;
    logic        rd_fire;
    logic        rd_load;
    logic [7:0]  rd_data;

    // Fixed ROM image.
    function automatic logic [7:0] rom_byte(input logic [14:0] idx);
        if (idx == 15'd0)
            return 8'h4C;
        return idx[7:0] ^ {1'b0, idx[14:8]};
    endfunction

    // Address decode on the top address bits.
    function automatic region_t decode(input logic [15:0] a);
        if (a[15])
            return RG_ROM;
        case (a[14:13])
            2'b00:   return RG_RAM;
            2'b01:   return RG_IO;
            2'b10:   return RG_NONE;
            default: return RG_SRAM;
        endcase
    endfunction

    // Request qualification: WAIT ignores the bus; write wins over read.
    always_comb begin
        region  = decode(cpu_addr_out);
        accept  = (state != WAIT);
        wr_fire = accept && wen;
        rd_fire = accept && ren && !wen;
    end

    // Single-cycle read data mux; rd_load=0 means keep cpu_data_in as is.
    always_comb begin
        rd_data = 8'h00;
        rd_load = 1'b1;
        case (region)
            RG_RAM:  rd_data = ram[cpu_addr_out[10:0]];
            RG_IO:   rd_data = io_regs[cpu_addr_out[2:0]];
            RG_SRAM: rd_data = sram[cpu_addr_out[12:0]];
            RG_ROM:  rd_data = rom_byte(cpu_addr_out[14:0]);
            default: begin
`ifdef CPU_MEM_OPEN_BUS_EN
                rd_load = 1'b0;
`else
                rd_data = 8'h00;
`endif
            end
        endcase
    end

    // Memory arrays: written on accepted writes, never cleared by reset.
    always_ff @(posedge clk) begin
        if (b_rst && wr_fire) begin
            case (region)
                RG_RAM:  ram[cpu_addr_out[10:0]]    <= cpu_data_out;
                RG_IO:   io_regs[cpu_addr_out[2:0]] <= cpu_data_out;
                RG_SRAM: sram[cpu_addr_out[12:0]]   <= cpu_data_out;
                default: ;
            endcase
        end
    end

    // Latch the ROM index so the address bus may change during WAIT.
    always_ff @(posedge clk) begin
        if (rd_fire && region == RG_ROM)
            rom_idx <= cpu_addr_out[14:0];
    end

    // Control FSM with registered rdy, read data and IO write strobe.
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state       <= IDLE;
            wait_cnt    <= 3'd0;
            cpu_data_in <= 8'h00;
            rdy         <= 1'b1;
            io_wr       <= 1'b0;
            io_sel      <= 3'd0;
        end else begin
            io_wr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    if (wr_fire) begin
                        if (region == RG_IO) begin
                            io_wr  <= 1'b1;
                            io_sel <= cpu_addr_out[2:0];
                        end
                    end else if (rd_fire) begin
                        if (region == RG_ROM && ROM_HAS_WAIT) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                            rdy      <= 1'b0;
                        end else if (rd_load) begin
                            cpu_data_in <= rd_data;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        cpu_data_in <= rom_byte(rom_idx);
                        state       <= DONE;
                        rdy         <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder: directed bus vectors with a read-data
// scoreboard. Stimulus pushes the expected byte for each read; a monitor
// watches the bus handshake and pops/compares when read data is due.

module tb_cpu_mem_responder;

    localparam int ROM_WAIT = 2;

    logic        clk = 1'b0;
    logic        b_rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  cpu_data_in;
    logic        rdy;
    logic        io_wr;
    logic [2:0]  io_sel;

    logic [7:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

`ifdef CPU_MEM_OPEN_BUS_EN
    localparam logic [7:0] UNMAPPED_AFTER_1E = 8'h1E;
`else
    localparam logic [7:0] UNMAPPED_AFTER_1E = 8'h00;
`endif

    cpu_mem_responder #(.ROM_WAIT(ROM_WAIT)) dut (
        .clk          (clk),
        .b_rst        (b_rst),
        .cpu_addr_out (addr),
        .cpu_data_out (wdata),
        .ren          (ren),
        .wen          (wen),
        .cpu_data_in  (cpu_data_in),
        .rdy          (rdy),
        .io_wr        (io_wr),
        .io_sel       (io_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: rdy stayed low, wanted high within 20 cycles", name);
    endtask

    // Issue a read at a negedge; returns at the first negedge with rdy high.
    task automatic do_read(input logic [15:0] a, input logic [7:0] e, output int lowc);
        int guard;
        guard = 0;
        while (!rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) bound_fail("rd_start");
        exp_q.push_back(e);
        addr = a;
        ren  = 1'b1;
        wen  = 1'b0;
        @(negedge clk);
        ren  = 1'b0;
        lowc = 0;
        while (!rdy && lowc < 20) begin
            @(negedge clk);
            lowc++;
        end
        if (lowc >= 20) bound_fail("rd_done");
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        ren   = 1'b0;
        @(negedge clk);
        wen   = 1'b0;
        chk("wr_rdy_high", rdy, 1);
    endtask

    task automatic pop_cmp(input logic [15:0] a);
        logic [7:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected @%04h: got %02h expected no read", a, cpu_data_in);
        end else begin
            e = exp_q.pop_front();
            if (cpu_data_in !== e) begin
                n_err++;
                $display("FAIL rd_data @%04h: got %02h expected %02h", a, cpu_data_in, e);
            end
        end
    endtask

    // Monitor: detects accepted reads and checks data when it is due.
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    bit          rom_waits = (ROM_WAIT > 0);

    always @(posedge clk) begin
        logic        acc;
        logic [15:0] a_s;
        acc = rdy && ren && !wen;
        a_s = addr;
        if (!b_rst) begin
            pend = 1'b0;
        end else if (pend) begin
            #1;
            if (rdy) begin
                pend = 1'b0;
                pop_cmp(pend_addr);
            end else begin
                pend_cnt++;
                if (pend_cnt > 16) begin
                    pend = 1'b0;
                    n_vec++;
                    n_err++;
                    $display("FAIL rom_latency @%04h: got no data expected data within 16 cycles", pend_addr);
                end
            end
        end else if (acc) begin
            if (a_s[15] && rom_waits) begin
                pend      = 1'b1;
                pend_cnt  = 0;
                pend_addr = a_s;
            end else begin
                #1;
                pop_cmp(a_s);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        #2 b_rst = 1'b0;
        #1;
        chk("rst_data", cpu_data_in, 8'h00);
        chk("rst_rdy", rdy, 1);
        chk("rst_io_wr", io_wr, 0);
        chk("rst_io_sel", io_sel, 3'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b1;

        // First edge after release accepts a ROM read: $8123 -> 23^01
        do_read(16'h8123, 8'h22, lc);
        chk("first_rom_rdy_low", lc, ROM_WAIT);

        do_write(16'h0123, 8'hA5);
        do_read(16'h0923, 8'hA5, lc);
        chk("ram_rdy_low", lc, 0);

        do_read(16'h8000, 8'h4C, lc);
        chk("rom_rdy_low", lc, ROM_WAIT);
        // Accepted from DONE: $FFFF -> FF^7F
        do_read(16'hFFFF, 8'h80, lc);
        chk("rom_done_rdy_low", lc, ROM_WAIT);

        do_write(16'h3FFA, 8'h1E);
        chk("io_wr_pulse", io_wr, 1);
        chk("io_sel_2", io_sel, 3'd2);
        @(negedge clk);
        chk("io_wr_end", io_wr, 0);
        chk("io_sel_hold", io_sel, 3'd2);
        do_read(16'h2002, 8'h1E, lc);
        do_read(16'h2000 + 16'h0002, 8'h1E, lc);
        do_read(16'h4500, UNMAPPED_AFTER_1E, lc);

        do_write(16'h0005, 8'h3C);
        chk("io_sel_after_ram", io_sel, 3'd2);
        do_read(16'h0805, 8'h3C, lc);
        do_read(16'h1805, 8'h3C, lc);

        do_write(16'h6000, 8'h5A);
        do_write(16'h7FFF, 8'hC3);
        do_read(16'h6000, 8'h5A, lc);
        do_read(16'h7FFF, 8'hC3, lc);

        do_write(16'h2005, 8'h6B);
        chk("io_sel_5", io_sel, 3'd5);
        do_read(16'h3FFD, 8'h6B, lc);

        // Unmapped write must not land in RAM
        do_write(16'h4005, 8'h99);
        do_read(16'h0005, 8'h3C, lc);

        // ren+wen together: write only, read data unchanged
        do_read(16'h0123, 8'hA5, lc);
        addr  = 16'h0010;
        wdata = 8'h77;
        ren   = 1'b1;
        wen   = 1'b1;
        @(negedge clk);
        ren   = 1'b0;
        wen   = 1'b0;
        chk("both_data_kept", cpu_data_in, 8'hA5);
        do_read(16'h0010, 8'h77, lc);

        // ROM write is dropped
        do_write(16'h8000, 8'hFF);
        do_read(16'h8000, 8'h4C, lc);

        // Reset during WAIT abandons the ROM read
        addr = 16'h8000;
        ren  = 1'b1;
        @(negedge clk);
        ren  = 1'b0;
        chk("wait_rdy_low", rdy, 0);
        b_rst = 1'b0;
        #1;
        chk("mid_rst_rdy", rdy, 1);
        chk("mid_rst_data", cpu_data_in, 8'h00);
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_late_data", cpu_data_in, 8'h00);
        chk("no_late_rdy", rdy, 1);
        do_read(16'h6000, 8'h5A, lc);
        chk("sram_after_rst_lat", lc, 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
